// File: rtl/als_spi_responder.sv
// ---------------------------------------------------------------------------
// als_spi_responder
//
// Purpose:
//   SPI responder that stands in for an 8-bit ambient-light-sensor ADC
//   (ADC081S021-style frame). It lets the light-sensor SPI reader run on the
//   board or in simulation without the Pmod fitted. The reader's cs/sclk are
//   sampled in the clk domain. Each frame shifts out a word of LEAD_ZEROS zero
//   bits, then DATA_WIDTH data bits (MSB first), then trailing zero bits. The
//   data value comes from a shadow register that the host can write.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   cs          in   chip select from the reader, active-low, asynchronous to clk
//   sclk        in   serial clock from the reader, asynchronous to clk
//   sdata       out  serial data to the reader, MSB first
//   sdata_oe    out  1 while sdata is driven (frame open); the top level tri-states otherwise
//   sample_in   in   value to report in later frames
//   sample_we   in   one-cycle write strobe for sample_in into the shadow register
//   busy        out  a frame is in progress
//   frame_done  out  one-cycle pulse: cs rose after all FRAME_BITS rising edges
//   frame_abort out  one-cycle pulse: cs rose before FRAME_BITS rising edges
// ---------------------------------------------------------------------------
module als_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_ZEROS  = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  sclk,
  output logic                  sdata,
  output logic                  sdata_oe,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_we,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort
);

  localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam int CNT_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_e;

  // Synchronizers and edge-detect history. These reset to 1 so that an idle
  // (high) cs does not produce a false edge when reset is released.
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic                   cs_hist_q, sclk_hist_q;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  word_q, word_d;
  logic [CNT_W-1:0]       rise_cnt_q, rise_cnt_d;
  logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
  logic                   sdata_q, sdata_d;
  logic                   sdata_oe_q, sdata_oe_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_abort_q, frame_abort_d;

  logic [FRAME_BITS-1:0]  frame_new;
  logic [FRAME_BITS-1:0]  word_shifted;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_hist_q & ~cs_s;
  assign cs_rise   = ~cs_hist_q & cs_s;
  assign sclk_rise = ~sclk_hist_q & sclk_s;
  assign sclk_fall = sclk_hist_q & ~sclk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      cs_hist_q   <= 1'b1;
      sclk_hist_q <= 1'b1;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      cs_hist_q   <= cs_s;
      sclk_hist_q <= sclk_s;
    end
  end

  // The frame word is built from the shadow value as it is *before* any write
  // in the same cycle. A write that coincides with cs_fall therefore shows up
  // only from the next frame on.
  assign frame_new = FRAME_BITS'(shadow_q) << TRAIL_ZEROS;

  // After k rising edges the next bit to present is word[FRAME_BITS-1-k].
  // That bit is the MSB of the word shifted left by k.
  assign word_shifted = word_q << rise_cnt_q;

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    rise_cnt_d    = rise_cnt_q;
    sdata_d       = sdata_q;
    sdata_oe_d    = sdata_oe_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    shadow_d      = sample_we ? sample_in : shadow_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          word_d     = frame_new;
          rise_cnt_d = '0;
          sdata_d    = frame_new[FRAME_BITS-1];
          sdata_oe_d = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // A cs_rise takes priority, so an sclk edge in the same cycle is dropped.
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          sdata_oe_d    = 1'b0;
          sdata_d       = 1'b0;
          state_d       = IDLE;
        end else if (sclk_rise) begin
          rise_cnt_d = rise_cnt_q + CNT_W'(1);
          if (rise_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            state_d = HOLD;
          end
        end else if (sclk_fall && (rise_cnt_q != '0)) begin
          // A falling edge before the first rise is the CPOL=1 lead edge.
          // It must not advance the data.
          sdata_d = word_shifted[FRAME_BITS-1];
        end
      end
      HOLD: begin
        if (cs_rise) begin
          frame_done_d = 1'b1;
          sdata_oe_d   = 1'b0;
          sdata_d      = 1'b0;
          state_d      = IDLE;
        end else if (sclk_fall) begin
          sdata_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      word_q        <= '0;
      rise_cnt_q    <= '0;
      shadow_q      <= '0;
      sdata_q       <= 1'b0;
      sdata_oe_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      rise_cnt_q    <= rise_cnt_d;
      shadow_q      <= shadow_d;
      sdata_q       <= sdata_d;
      sdata_oe_q    <= sdata_oe_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign sdata       = sdata_q;
  assign sdata_oe    = sdata_oe_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_als_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_als_spi_responder
//
// Purpose:
//   Self-checking bench for als_spi_responder. A reader model drives cs/sclk
//   in CPOL 0 or 1 and captures sdata on each sclk rise. For every frame, the
//   expected end pulse and captured bit string are pushed to a queue. A monitor
//   pops one entry each time frame_done or frame_abort appears.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_als_spi_responder;

  localparam int HALF = 5;

  typedef struct {
    bit          done;
    int          nbits;
    logic [31:0] bits;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       sclk;
  logic       sdata;
  logic       sdata_oe;
  logic [7:0] sample_in;
  logic       sample_we;
  logic       busy;
  logic       frame_done;
  logic       frame_abort;

  int          n_checks;
  int          n_fail;
  exp_t        exp_q[$];
  logic [7:0]  model_shadow;
  logic [31:0] cap_bits;
  int          cap_n;

  als_spi_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .sclk        (sclk),
    .sdata       (sdata),
    .sdata_oe    (sdata_oe),
    .sample_in   (sample_in),
    .sample_we   (sample_we),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point, so every check is counted the same way.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference behaviour: the reader sees the 16-bit word
  // 3 zeros | sample | 5 zeros, MSB first. Every rise past the 16th reads 0.
  function automatic exp_t expect_frame(input logic [7:0] value, input int n_rise);
    exp_t        e;
    logic [15:0] word;
    word    = {3'b000, value, 5'b00000};
    e.done  = (n_rise >= 16);
    e.nbits = n_rise;
    e.bits  = '0;
    for (int k = 0; k < n_rise; k++) begin
      e.bits = {e.bits[30:0], (k < 16) ? word[15-k] : 1'b0};
    end
    return e;
  endfunction

  task automatic write_sample(input logic [7:0] v);
    @(negedge clk);
    sample_in = v;
    sample_we = 1'b1;
    @(negedge clk);
    sample_we = 1'b0;
    model_shadow = v;
  endtask

  // Runs one reader frame. A mid-frame write happens just before rise number
  // wr_at. If we_at_fall is set, a write lands in the same cycle that the
  // responder acts on cs falling.
  task automatic apply_stimulus(input bit cpol, input int n_rise, input int wr_at,
                                input logic [7:0] wr_val, input bit we_at_fall,
                                input logic [7:0] fall_val);
    logic [31:0] cap;
    @(negedge clk);
    sclk = cpol;
    repeat (6) @(negedge clk);
    exp_q.push_back(expect_frame(model_shadow, n_rise));
    cs = 1'b0;
    if (we_at_fall) begin
      @(negedge clk);
      @(negedge clk);
      sample_in = fall_val;
      sample_we = 1'b1;
      @(negedge clk);
      sample_we = 1'b0;
      model_shadow = fall_val;
      repeat (4) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    cap = '0;
    for (int k = 0; k < n_rise; k++) begin
      if (k == wr_at) write_sample(wr_val);
      if (cpol) begin
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      check_output("in_frame", {30'b0, busy, sdata_oe}, 32'h3);
      cap = {cap[30:0], sdata};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (!cpol) begin
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    cap_bits = cap;
    cap_n    = n_rise;
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: pops one expectation for every end-of-frame pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (frame_done || frame_abort)) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_pulse", {30'b0, frame_done, frame_abort}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check_output("pulse_kind", {30'b0, frame_done, frame_abort},
                       e.done ? 32'h2 : 32'h1);
          check_output("frame_bits", cap_bits, e.bits);
          check_output("frame_len", cap_n, e.nbits);
          check_output("idle_after_frame", {29'b0, busy, sdata_oe, sdata}, 32'h0);
        end
      end
    end
  end

  // Bounds the run in case the design or the bench stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    model_shadow = 8'h00;
    cap_bits     = '0;
    cap_n        = 0;
    sample_in    = 8'h00;
    sample_we    = 1'b0;
    cs           = 1'b0;
    sclk         = 1'b1;
    rst_n        = 1'b0;

    // Reset held while cs is low and sclk toggles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sclk = ~sclk;
    end
    check_output("reset_outputs", {27'b0, sdata, sdata_oe, busy, frame_done, frame_abort}, 32'h0);
    cs   = 1'b1;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_output("idle_after_reset", {27'b0, sdata, sdata_oe, busy, frame_done, frame_abort}, 32'h0);

    // Full frames in both clock polarities.
    write_sample(8'hA5);
    apply_stimulus(1'b1, 16, 99, 8'h00, 1'b0, 8'h00);
    write_sample(8'hFF);
    apply_stimulus(1'b0, 16, 99, 8'h00, 1'b0, 8'h00);

    // Abort after 7 rises, then a clean frame.
    write_sample(8'hA5);
    apply_stimulus(1'b1, 7, 99, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b1, 16, 99, 8'h00, 1'b0, 8'h00);

    // Write during a frame, then a write coinciding with cs falling.
    apply_stimulus(1'b1, 16, 4, 8'h3C, 1'b0, 8'h00);
    apply_stimulus(1'b0, 16, 99, 8'h00, 1'b0, 8'h00);
    write_sample(8'hA5);
    apply_stimulus(1'b1, 16, 99, 8'h00, 1'b1, 8'h3C);
    apply_stimulus(1'b1, 16, 99, 8'h00, 1'b0, 8'h00);

    // Extra rising edges in HOLD and an abort with no edges at all.
    apply_stimulus(1'b1, 20, 99, 8'h00, 1'b0, 8'h00);
    apply_stimulus(1'b0, 0, 99, 8'h00, 1'b0, 8'h00);

    // Reset in the middle of a frame: no pulse, outputs go to reset values.
    write_sample(8'h81);
    @(negedge clk);
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("midframe_reset", {27'b0, sdata, sdata_oe, busy, frame_done, frame_abort}, 32'h0);
    cs   = 1'b1;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_shadow = 8'h00;
    repeat (6) @(negedge clk);
    apply_stimulus(1'b1, 16, 99, 8'h00, 1'b0, 8'h00);
    write_sample(8'h5A);
    apply_stimulus(1'b0, 16, 99, 8'h00, 1'b0, 8'h00);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      bit         cpol;
      int         n_rise;
      int         wr_at;
      bit         at_fall;
      logic [7:0] v1;
      logic [7:0] v2;
      cpol    = 1'($urandom_range(0, 1));
      n_rise  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(16, 20))
                                            : int'($urandom_range(0, 15));
      wr_at   = int'($urandom_range(0, 25));
      at_fall = ($urandom_range(0, 3) == 0);
      v1      = 8'($urandom);
      v2      = 8'($urandom);
      if ($urandom_range(0, 1) != 0) write_sample(8'($urandom));
      apply_stimulus(cpol, n_rise, wr_at, v1, at_fall, v2);
    end

    repeat (20) @(negedge clk);
    check_output("pending_expectations", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
